// File: rtl/nrisc_mem_port_master_pkg.sv
// Shared definitions for the DataMEM port master: width defaults, FSM encoding, opcode bit.
package nrisc_mem_port_master_pkg;

  localparam int unsigned TamDefault  = 16;
  localparam int unsigned LmemDefault = 8;

  // Value of req_write that selects a store.
  localparam logic OpStore = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWr    = 3'd1,
    StRd    = 3'd2,
    StRwait = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/nrisc_mem_port_master.sv
// Core-side initiator for one DataMEM port: accepts one load/store, strobes memory, returns
// read data or a store ack. All outputs come straight from flops.
module nrisc_mem_port_master
  import nrisc_mem_port_master_pkg::*;
#(
  parameter int unsigned TAM    = TamDefault,
  parameter int unsigned Lmem   = LmemDefault,
  parameter int unsigned RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [TAM-1:0] req_addr,
  input  logic [TAM-1:0] req_wdata,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [TAM-1:0] resp_rdata,
  output logic           resp_err,
  output logic [TAM-1:0] dataADDR,
  output logic [TAM-1:0] dataIN,
  input  logic [TAM-1:0] dataOUT,
  output logic           dataLoad,
  output logic           dataWrite
);

  localparam int unsigned CntW = $clog2(RD_LAT) + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TAM-1:0]  addr_q, addr_d;
  logic [TAM-1:0]  wdata_q, wdata_d;
  logic [TAM-1:0]  rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            load_q, load_d;
  logic            write_q, write_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            addr_err;

  assign addr_err = |req_addr[TAM-1:Lmem];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        // ready_q gates the accept so the core's view of req_ready is exactly what is honoured.
        if (req_valid && ready_q) begin
          rdata_d = '0;
          err_d   = addr_err;
          if (addr_err) begin
            state_d = StResp;
          end else begin
            addr_d = req_addr;
            if (req_write == OpStore) begin
              wdata_d = req_wdata;
              state_d = StWr;
            end else begin
              state_d = StRd;
            end
          end
        end
      end
      StWr: state_d = StResp;
      StRd: begin
        cnt_d   = CntW'(RD_LAT - 1);
        state_d = StRwait;
      end
      StRwait: begin
        if (cnt_q == '0) begin
          rdata_d = dataOUT;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered versions of the next-state decode.
    load_d  = (state_d == StRd);
    write_d = (state_d == StWr);
    valid_d = (state_d == StResp);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      load_q  <= load_d;
      write_q <= write_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dataADDR   = addr_q;
  assign dataIN     = wdata_q;
  assign dataLoad   = load_q;
  assign dataWrite  = write_q;

endmodule
